rom_burst_reader: RTL

Parametrised successor to the team's fixed 512x8 lookup ROM. Holds constant table data in a registered-read array and streams bursts of consecutive words on a valid/ready output channel. A start request supplies the base address and length. Sits between a control sequencer (issues bursts) and a consumer datapath (may apply backpressure).

---
 rtl/rom_pkg.sv | 25 ++
 rtl/rom_burst_reader_if.sv | 32 +++
 rtl/rom_array.sv | 33 +++
 rtl/rom_burst_reader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_pkg
// Brief    : Shared defaults, table contents and FSM encoding for the burst ROM.
// Revision : 1.0 - initial release
// ============================================================================
package rom_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 9;
    localparam logic [c_DATA_W-1:0] c_FILL_VAL = '1;

    // Low-address table; everything above it reads as the fill value.
    localparam int c_TABLE_LEN = 4;
    localparam logic [7:0] c_ROM_TABLE [c_TABLE_LEN] = '{8'd27, 8'd5, 8'h21, 8'd3};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ZERO  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader_if
// Brief    : Burst request and beat stream channels of the burst ROM reader.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_burst_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
);
    logic              startValid;
    logic              startReady;
    logic [ADDR_W-1:0] startAddr;
    logic [ADDR_W:0]   burstLen;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic              outLast;
    logic              busy;
    logic              done;

    modport master (
        output startValid, startAddr, burstLen, outReady,
        input  startReady, outValid, outData, outLast, busy, done
    );

    modport slave (
        input  startValid, startAddr, burstLen, outReady,
        output startReady, outValid, outData, outLast, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rom_array.sv
`default_nettype none
// ============================================================================
// Module   : rom_array
// Brief    : Registered-read constant memory; data appears one cycle after rd_en.
// Revision : 1.0 - initial release
// ============================================================================
module rom_array
    import rom_pkg::*;
#(
    parameter int                 DATA_W   = c_DATA_W,
    parameter int                 ADDR_W   = c_ADDR_W,
    parameter logic [DATA_W-1:0]  FILL_VAL = {DATA_W{1'b1}}
) (
    input  wire logic              clk,
    input  wire logic              i_rd_en,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [DATA_W-1:0] o_rd_data
);

    function automatic logic [DATA_W-1:0] f_word(input logic [ADDR_W-1:0] a);
        if (int'(a) < c_TABLE_LEN)
            return DATA_W'(c_ROM_TABLE[a[1:0]]);
        return FILL_VAL;
    endfunction

    // Output register holds its value while rd_en is low, so it doubles as a stall stage.
    always_ff @(posedge clk) begin
        if (i_rd_en)
            o_rd_data <= f_word(i_rd_addr);
    end

endmodule
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader
// Brief    : Streams bursts of consecutive ROM words through a 2-entry skid buffer.
//            Macro ROM_WRAP_EN: wrap addresses modulo DEPTH instead of truncating.
// Revision : 1.0 - initial release
// ============================================================================
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int                 DATA_W   = c_DATA_W,
    parameter int                 ADDR_W   = c_ADDR_W,
    parameter logic [DATA_W-1:0]  FILL_VAL = {DATA_W{1'b1}}
) (
    input  wire logic        control,
    input  wire logic        resetN,
    rom_burst_reader_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_LEN_ONE  = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_left;
    logic              r_rd_vld;
    logic              r_rd_last;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_d0, r_d1;
    logic              r_l0, r_l1;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_rd_data;
    logic              w_pop, w_push, w_issue, w_issue_last, w_at_end;

    assign w_pop  = (r_cnt != 2'd0) && bus.outReady;
    assign w_push = r_rd_vld && ((r_cnt != 2'd2) || w_pop);
    // Only issue when the ROM output stage is free or draining this cycle.
    assign w_issue = (r_state == FETCH) && (r_left != '0) && (!r_rd_vld || w_push);

`ifdef ROM_WRAP_EN
    assign w_at_end = 1'b0;
`else
    assign w_at_end = (r_addr == {ADDR_W{1'b1}});
`endif
    assign w_issue_last = (r_left == c_LEN_ONE) || w_at_end;

    rom_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .FILL_VAL (FILL_VAL)
    ) u_rom_array (
        .clk       (control),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge control or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_left    <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_cnt     <= 2'd0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_l0      <= 1'b0;
            r_l1      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.startValid) begin
                        r_addr  <= bus.startAddr;
                        r_left  <= bus.burstLen;
                        r_busy  <= 1'b1;
                        r_state <= (bus.burstLen == '0) ? ZERO : FETCH;
                    end
                end
                FETCH: begin
                    if (w_pop && r_l0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                ZERO: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase

            if (w_issue) begin
                r_addr <= r_addr + c_ADDR_ONE;
                r_left <= w_issue_last ? '0 : r_left - c_LEN_ONE;
            end

            if (w_issue) begin
                r_rd_vld  <= 1'b1;
                r_rd_last <= w_issue_last;
            end else if (w_push) begin
                r_rd_vld  <= 1'b0;
            end

            // Skid buffer: entry 0 is the head presented on the output.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_d0 <= w_rd_data;
                        r_l0 <= r_rd_last;
                    end else begin
                        r_d1 <= w_rd_data;
                        r_l1 <= r_rd_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= (r_cnt == 2'd2) ? r_l1 : 1'b0;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= w_rd_data;
                        r_l0 <= r_rd_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= w_rd_data;
                        r_l1 <= r_rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.startReady = !r_busy;
    assign bus.outValid   = (r_cnt != 2'd0);
    assign bus.outData    = r_d0;
    assign bus.outLast    = r_l0;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire
